core_sequencer: RTL and testbench

Multi-cycle control unit for the 8-bit-PC RISC datapath: instruction memory, register file, and ALU with a flag output. It replaces the free-running single-cycle PC logic with an explicit FETCH/EXEC/WB state machine that owns the PC, latches the instruction, and gates RF writes. It also gives the host a start/halt/single-step handshake. It sits between the instruction memory and the RF/ALU.

---
 rtl/core_pkg.sv | 33 +++
 rtl/core_pc_next.sv | 26 ++
 rtl/core_sequencer.sv | 132 +++++++++++++
 tb/tb_core_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core sequencer: FSM state encoding,
// instruction field positions and write-data mux encodings.
package core_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_PAUSE = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    // Instruction field positions
    localparam int JUMP_BIT   = 31;
    localparam int BRANCH_BIT = 30;
    localparam int WSRC_HI    = 29;
    localparam int WSRC_LO    = 28;
    localparam int OFF_HI     = 12;
    localparam int OFF_LO     = 5;

    // Write-data mux select encodings
    localparam logic [1:0] WD_ALU     = 2'b01;
    localparam logic [1:0] WD_CONST   = 2'b10;
    localparam logic [1:0] WD_ILLEGAL = 2'b11;

    // True when the write-source field holds the reserved encoding
    function automatic logic wsrc_illegal(input logic [31:0] word);
        return (word[WSRC_HI:WSRC_LO] == WD_ILLEGAL);
    endfunction

endpackage

// File: rtl/core_pc_next.sv
// Next-PC evaluation for the sequencer: decides whether the latched
// instruction's control transfer is taken, whether it is a self-jump
// (jump with zero offset, used as the halt idiom), and the wrapped next PC.
module core_pc_next
    import core_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic            jump,
    input  logic            branch,
    input  logic [7:0]      offset,
    input  logic            flag_q,
    output logic            taken,
    output logic            self_jump,
    output logic [PC_W-1:0] pc_next
);

    // Offset is unsigned; addition wraps naturally at PC_W bits
    always_comb begin
        taken     = jump | (branch & flag_q);
        self_jump = jump & (offset == 8'd0);
        pc_next   = taken ? (pc + PC_W'(offset)) : (pc + PC_W'(1));
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/EXEC/WB control unit for the 8-bit-PC RISC datapath.
// Owns the PC, latches the instruction, gates RF writes and provides the
// host start/halt/single-step handshake.
// Optional feature: define CORE_SEQ_RETIRE_CNT_EN to add a saturating
// 32-bit retired-instruction counter output.
module core_sequencer
    import core_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step_en,
    input  logic            step,
    input  logic [31:0]     instr_i,
    input  logic            alu_flag,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     instr_q,
    output logic            rf_we,
    output logic [1:0]      wd_sel,
    output logic            busy,
    output logic            halted,
    output logic            err
`ifdef CORE_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]     retired
`endif
);

    state_t          state_reg;
    logic            flag_q;
    logic            taken;
    logic            self_jump;
    logic [PC_W-1:0] pc_next;

    core_pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc        (pc),
        .jump      (instr_q[JUMP_BIT]),
        .branch    (instr_q[BRANCH_BIT]),
        .offset    (instr_q[OFF_HI:OFF_LO]),
        .flag_q    (flag_q),
        .taken     (taken),
        .self_jump (self_jump),
        .pc_next   (pc_next)
    );

    // Sequencer FSM: state, PC, latched instruction, flag and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc        <= '0;
            instr_q   <= '0;
            flag_q    <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_HALT: begin
                    // start takes priority over any step on the same edge
                    if (start) begin
                        pc        <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        halted    <= 1'b0;
                        state_reg <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    instr_q   <= instr_i;
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    flag_q <= alu_flag;
                    if (wsrc_illegal(instr_q)) begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        halted    <= 1'b1;
                        state_reg <= ST_HALT;
                    end else begin
                        state_reg <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (self_jump) begin
                        // PC holds on the halting self-jump
                        busy      <= 1'b0;
                        halted    <= 1'b1;
                        state_reg <= ST_HALT;
                    end else begin
                        pc        <= pc_next;
                        state_reg <= step_en ? ST_PAUSE : ST_FETCH;
                    end
                end
                ST_PAUSE: begin
                    if (step) begin
                        state_reg <= ST_FETCH;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    halted    <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CORE_SEQ_RETIRE_CNT_EN
    // Retired-instruction counter: counts every WB cycle, saturates at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if ((state_reg == ST_IDLE || state_reg == ST_HALT) && start) begin
            retired <= '0;
        end else if (state_reg == ST_WB && retired != 32'hFFFF_FFFF) begin
            retired <= retired + 32'd1;
        end
    end
`endif

    // RF write strobe decoded from registered state only, so it is glitch-free
    // and drops as soon as the asynchronous reset clears the state
    always_comb begin
        rf_we  = (state_reg == ST_WB) & (instr_q[WSRC_HI] ^ instr_q[WSRC_LO]);
        wd_sel = instr_q[WSRC_HI:WSRC_LO];
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: an instruction-level reference model
// predicts RF-write and halt events into a queue; a monitor pops and compares.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        step_en;
    logic        step;
    logic [31:0] instr_i;
    logic        alu_flag;
    logic [7:0]  pc;
    logic [31:0] instr_q;
    logic        rf_we;
    logic [1:0]  wd_sel;
    logic        busy;
    logic        halted;
    logic        err;
    logic [31:0] retired;

    logic [31:0] imem [256];
    logic        flag_inv = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc = 0;

    typedef struct {
        int          kind;      // 0 = RF write, 1 = halt
        logic [7:0]  pc;
        logic [31:0] word;
        logic [1:0]  wsel;
        logic        err;
        int          cyc;       // cycles after start edge, -1 = don't care
        logic [31:0] ret;
    } ev_t;

    ev_t exp_q[$];

    core_sequencer #(.PC_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .step_en  (step_en),
        .step     (step),
        .instr_i  (instr_i),
        .alu_flag (alu_flag),
        .pc       (pc),
        .instr_q  (instr_q),
        .rf_we    (rf_we),
        .wd_sel   (wd_sel),
        .busy     (busy),
        .halted   (halted),
        .err      (err)
`ifdef CORE_SEQ_RETIRE_CNT_EN
        ,
        .retired  (retired)
`endif
    );

`ifndef CORE_SEQ_RETIRE_CNT_EN
    assign retired = 32'd0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Environment: combinational instruction memory and a toy ALU flag
    assign instr_i  = imem[pc];
    assign alu_flag = (^instr_q[27:18]) ^ flag_inv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Instruction-level reference: runs up to k instructions from pc=0
    task automatic model_run(input int k, input bit stepmode,
                             output bit halts, output logic [7:0] fpc);
        logic [7:0]  mpc = 8'd0;
        logic [31:0] ret = 32'd0;
        logic [31:0] w;
        logic [1:0]  ws;
        logic [7:0]  off;
        logic        flag, tk;
        ev_t         e;
        halts = 1'b0;
        for (int i = 1; i <= k; i++) begin
            w   = imem[mpc];
            ws  = w[29:28];
            off = w[12:5];
            if (ws == 2'b11) begin
                e = '{1, mpc, w, ws, 1'b1, stepmode ? -1 : 3*i-1, ret};
                exp_q.push_back(e);
                halts = 1'b1;
                fpc = mpc;
                return;
            end
            if (ws != 2'b00) begin
                e = '{0, mpc, w, ws, 1'b0, stepmode ? -1 : 3*i-1, 32'd0};
                exp_q.push_back(e);
            end
            ret++;
            flag = (^w[27:18]) ^ flag_inv;
            tk   = w[31] | (w[30] & flag);
            if (w[31] && off == 8'd0) begin
                e = '{1, mpc, w, ws, 1'b0, stepmode ? -1 : 3*i, ret};
                exp_q.push_back(e);
                halts = 1'b1;
                fpc = mpc;
                return;
            end
            mpc = tk ? mpc + off : mpc + 8'd1;
        end
        fpc = mpc;
    endtask

    // Monitor: compares every RF write and every halt entry against the queue
    bit hprev = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            hprev = 1'b0;
        end else begin
            if (rf_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rf_we", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_kind_wr", 32'd0, 32'(e.kind));
                    chk("wr_pc", 32'(pc), 32'(e.pc));
                    chk("wr_instr_q", instr_q, e.word);
                    chk("wr_wd_sel", 32'(wd_sel), 32'(e.wsel));
                    if (e.cyc >= 0) chk("wr_cycle", 32'(cyc - start_cyc), 32'(e.cyc));
                end
            end
            if (halted && !hprev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_halt", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_kind_halt", 32'd1, 32'(e.kind));
                    chk("halt_pc", 32'(pc), 32'(e.pc));
                    chk("halt_err", 32'(err), 32'(e.err));
                    chk("halt_rf_we", 32'(rf_we), 32'd0);
                    if (e.cyc >= 0) chk("halt_cycle", 32'(cyc - start_cyc), 32'(e.cyc));
`ifdef CORE_SEQ_RETIRE_CNT_EN
                    chk("halt_retired", retired, e.ret);
`endif
                end
            end
            hprev = halted;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_pc", 32'(pc), 32'd0);
        chk("start_err", 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Runs the loaded program for at most k instructions and checks the outcome
    task automatic run_prog(input int k, input string nm);
        bit         halts;
        logic [7:0] fpc;
        bit         seen = 1'b0;
        model_run(k, 1'b0, halts, fpc);
        pulse_start();
        if (halts) begin
            for (int c = 0; c < 3*k + 4 && !seen; c++) begin
                @(negedge clk);
                #1;
                seen = halted;
            end
            chk({nm, "_halt_seen"}, 32'(seen), 32'd1);
            repeat (2) @(negedge clk);
            chk({nm, "_halt_busy"}, 32'(busy), 32'd0);
            chk({nm, "_halt_pc_held"}, 32'(pc), 32'(fpc));
            chk({nm, "_queue"}, 32'(exp_q.size()), 32'd0);
            if (!seen) do_reset();
        end else begin
            while (cyc < start_cyc + 3*k) @(negedge clk);
            #1;
            chk({nm, "_final_pc"}, 32'(pc), 32'(fpc));
            chk({nm, "_running"}, 32'(busy), 32'd1);
            do_reset();
        end
        $display("run %s done checks=%0d", nm, checks);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        int r = $urandom_range(0, 99);
        w[29:28] = (r < 5) ? 2'b11 : 2'($urandom_range(0, 2));
        w[31] = ($urandom_range(0, 99) < 15);
        if (w[31] && $urandom_range(0, 99) < 30) w[12:5] = 8'd0;
        return w;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    endtask

    initial begin
        bit         hs;
        logic [7:0] fp;
        rst = 1'b1; start = 1'b0; step_en = 1'b0; step = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr_q", instr_q, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_retired", retired, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // First instruction write, then self-jump halt at pc=1
        imem[0] = 32'h2000_0003;
        imem[1] = 32'h8000_0000;
        run_prog(5, "first_write");

        // Branch at pc=4, flag set then clear
        clear_mem();
        imem[4] = 32'h4000_0040;
        imem[5] = 32'h8000_0000;
        imem[6] = 32'h8000_0000;
        flag_inv = 1'b1;
        run_prog(10, "branch_taken");
        chk("branch_taken_pc", 32'(pc), 32'd6);
        flag_inv = 1'b0;
        run_prog(10, "branch_not_taken");
        chk("branch_nt_pc", 32'(pc), 32'd5);

        // Jump to 7 then halt there
        clear_mem();
        imem[0] = 32'h8000_00E0;
        imem[7] = 32'h8000_0000;
        run_prog(5, "self_jump7");
        chk("self_jump7_halted", 32'(halted), 32'd1);

        // PC wrap with offset and with increment
        clear_mem();
        imem[0]   = 32'h8000_1FE0;
        imem[255] = 32'h8000_0060;
        imem[2]   = 32'h8000_0000;
        run_prog(6, "wrap_offset");
        imem[255] = 32'h2000_0007;
        run_prog(2, "wrap_inc");

        // Illegal write source sets err, next start clears it
        clear_mem();
        imem[0] = 32'h3000_0001;
        run_prog(3, "illegal");
        chk("illegal_err", 32'(err), 32'd1);
        imem[0] = 32'h8000_0000;
        run_prog(3, "after_illegal");

        // Single-step program
        clear_mem();
        imem[0] = 32'h2000_0003;
        imem[1] = 32'h1000_0004;
        imem[2] = 32'h8000_0000;
        step_en = 1'b1;
        model_run(3, 1'b1, hs, fp);
        pulse_start();
        while (cyc < start_cyc + 3) @(negedge clk);
        #1;
        chk("pause1_pc", 32'(pc), 32'd1);
        chk("pause1_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        chk("pause1_hold_pc", 32'(pc), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pause_start_ignored_pc", 32'(pc), 32'd1);
        chk("pause_start_ignored_busy", 32'(busy), 32'd1);
        step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("pause2_pc", 32'(pc), 32'd2);
        repeat (2) @(negedge clk);
        chk("pause2_hold_pc", 32'(pc), 32'd2);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        for (int c = 0; c < 10 && !halted; c++) @(negedge clk);
        #1;
        chk("step_halted", 32'(halted), 32'd1);
        chk("step_halt_pc", 32'(pc), 32'd2);
        chk("step_queue", 32'(exp_q.size()), 32'd0);
        step_en = 1'b0;

        // Asynchronous reset during WB
        clear_mem();
        imem[0] = 32'h2000_0005;
        model_run(1, 1'b0, hs, fp);
        pulse_start();
        while (cyc < start_cyc + 2) @(negedge clk);
        chk("wb_rf_we_before_rst", 32'(rf_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rf_we", 32'(rf_we), 32'd0);
        chk("async_pc", 32'(pc), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_halted", 32'(halted), 32'd0);
        chk("async_retired", retired, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("async_queue", 32'(exp_q.size()), 32'd0);

        // Randomized programs
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 256; i++) imem[i] = rand_word();
            flag_inv = 1'($urandom_range(0, 1));
            run_prog(30, $sformatf("rand%0d", t));
        end

        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
